// File: rtl/calc_pkg.sv
// Shared opcode constants, sequencer FSM states and mask-scan helper
// for the calculator op sequencer.
package calc_pkg;

  localparam logic [2:0] OP_ADD     = 3'd0;
  localparam logic [2:0] OP_SUB     = 3'd1;
  localparam logic [2:0] OP_ADD_OFS = 3'd2;
  localparam logic [2:0] OP_SUB_OFS = 3'd3;
  localparam logic [2:0] OP_CMP     = 3'd4;
  localparam logic [2:0] OP_CMP_OFS = 3'd5;
  localparam logic [2:0] OP_NONE    = 3'd7;

  typedef enum logic [1:0] {IDLE, ISSUE, OUT} state_t;

  // Lowest set mask bit at or above 'from'; OP_NONE when nothing remains.
  function automatic logic [2:0] first_op_from(input logic [5:0] mask, input logic [2:0] from);
    first_op_from = OP_NONE;
    for (int i = 5; i >= 0; i--)
      if (mask[i] && (i >= int'(from))) first_op_from = 3'(i);
  endfunction

endpackage

// File: rtl/calc_model.sv
// Combinational expected-value model of the multi-function calculator,
// used for result checking when CALC_SEQ_CHECK_EN is defined.
module calc_model
  import calc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       s,
  output logic [WIDTH:0]   y
);

  logic [WIDTH:0] ax, bx;
  assign ax = {1'b0, a};
  assign bx = {1'b0, b};

  always_comb begin
    y = '0;
    case (s)
      OP_ADD, OP_ADD_OFS: y = ax + bx;
      OP_SUB, OP_SUB_OFS: y = ax - bx;
      OP_CMP, OP_CMP_OFS: y = {{(WIDTH-2){1'b0}}, (a == b), (a > b), (a < b)};
      default:            y = '0;
    endcase
  end

endmodule

// File: rtl/calc_op_sequencer.sv
// Issues each opcode selected by a request mask to the calculator in ascending
// order and streams the results out. Define CALC_SEQ_CHECK_EN to flag mismatches on res_err.
module calc_op_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int RESP_LAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [5:0]       req_mask,
  output logic [WIDTH-1:0] calc_a,
  output logic [WIDTH-1:0] calc_b,
  output logic [2:0]       calc_s,
  input  logic [WIDTH:0]   calc_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2:0]       res_op,
  output logic [WIDTH:0]   res_y,
  output logic             res_last,
  output logic             res_err,
  output logic             busy
);

  localparam int CW = (RESP_LAT > 0) ? $clog2(RESP_LAT + 1) : 1;

  state_t           state, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [5:0]       mask_q;
  logic [2:0]       op_q;
  logic [CW-1:0]    wait_cnt;
  logic             accept, wait_done, capture, res_hs;

  assign accept    = req_valid && req_ready;
  assign wait_done = (wait_cnt == CW'(RESP_LAT));
  assign capture   = (state == ISSUE) && wait_done;
  assign res_hs    = res_valid && res_ready;
  assign calc_a    = a_q;
  assign calc_b    = b_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d   = state;
    req_ready = 1'b0;
    busy      = 1'b1;
    calc_s    = op_q;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        calc_s    = OP_NONE;
        if (req_valid && (req_mask != 6'd0)) state_d = ISSUE;
      end
      ISSUE: if (wait_done) state_d = OUT;
      OUT:   if (res_hs) state_d = res_last ? IDLE : ISSUE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      mask_q    <= '0;
      op_q      <= '0;
      wait_cnt  <= '0;
      res_valid <= 1'b0;
      res_y     <= '0;
      res_op    <= '0;
      res_last  <= 1'b0;
    end else begin
      if (accept) begin
        a_q      <= req_a;
        b_q      <= req_b;
        mask_q   <= req_mask;
        op_q     <= first_op_from(req_mask, 3'd0);
        wait_cnt <= '0;
      end
      if (state == ISSUE) wait_cnt <= wait_done ? '0 : wait_cnt + CW'(1);
      if (capture) begin
        res_valid <= 1'b1;
        res_y     <= calc_y;
        res_op    <= op_q;
        res_last  <= (first_op_from(mask_q, op_q + 3'd1) == OP_NONE);
      end
      // Retire the delivered opcode and move to the next one still pending.
      if ((state == OUT) && res_hs) begin
        res_valid      <= 1'b0;
        mask_q[op_q]   <= 1'b0;
        if (!res_last) op_q <= first_op_from(mask_q, op_q + 3'd1);
      end
    end
  end

`ifdef CALC_SEQ_CHECK_EN
  logic [WIDTH:0] exp_y;
  logic           err_q;

  calc_model #(.WIDTH(WIDTH)) u_model (
    .a(a_q),
    .b(b_q),
    .s(op_q),
    .y(exp_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)       err_q <= 1'b0;
    else if (capture) err_q <= (calc_y != exp_y);
  end

  assign res_err = err_q;
`else
  assign res_err = 1'b0;
`endif

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Scoreboard bench for calc_op_sequencer with a behavioural calculator attached.
module tb_calc_op_sequencer;

  localparam int W = 4;

  typedef struct {
    logic [2:0] op;
    logic [W:0] y;
    logic       last;
    logic       err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_a = '0, req_b = '0;
  logic [5:0]   req_mask = '0;
  logic [W-1:0] calc_a, calc_b;
  logic [2:0]   calc_s;
  logic [W:0]   calc_y;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [2:0]   res_op;
  logic [W:0]   res_y;
  logic         res_last, res_err, busy;
  logic         force_zero = 1'b0;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  calc_op_sequencer #(.WIDTH(W), .RESP_LAT(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_mask(req_mask),
    .calc_a(calc_a), .calc_b(calc_b), .calc_s(calc_s), .calc_y(calc_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_op(res_op),
    .res_y(res_y), .res_last(res_last), .res_err(res_err), .busy(busy)
  );

  function automatic logic [W:0] calc_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] s);
    logic [W:0] ax, bx;
    ax = {1'b0, a};
    bx = {1'b0, b};
    case (s)
      3'd0, 3'd2: return ax + bx;
      3'd1, 3'd3: return ax - bx;
      3'd4, 3'd5: return {2'b00, (a == b), (a > b), (a < b)};
      default:    return '0;
    endcase
  endfunction

  // Calculator stand-in; force_zero corrupts op0 results.
  always_comb begin
    calc_y = calc_fn(calc_a, calc_b, calc_s);
    if (force_zero && (calc_s == 3'd0)) calc_y = '0;
  end

  // Drive one request and push its expected results. Returns at the negedge after acceptance.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] m,
                      input bit zero_op0);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    if (!req_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout req_ready=%0b required=1", req_ready);
    end
    for (int i = 0; i < 6; i++) begin
      if (m[i]) begin
        e.op   = 3'(i);
        e.y    = (zero_op0 && i == 0) ? '0 : calc_fn(a, b, 3'(i));
        e.last = ((m >> (i + 1)) == 6'd0);
`ifdef CALC_SEQ_CHECK_EN
        e.err  = zero_op0 && (i == 0);
`else
        e.err  = 1'b0;
`endif
        sb.push_back(e);
      end
    end
    req_a = a; req_b = b; req_mask = m; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL %s_drain_timeout pending=%0d required=0", name, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Consumer side of the scoreboard: compares every result handshake.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && res_valid && res_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_result op=%0d y=%0d required=none", res_op, res_y);
        end else begin
          e = sb.pop_front();
          if ({res_op, res_y, res_last, res_err} !== {e.op, e.y, e.last, e.err}) begin
            failures++;
            $display("FAIL result op/y/last/err=%0d/%0d/%0b/%0b required=%0d/%0d/%0b/%0b",
                     res_op, res_y, res_last, res_err, e.op, e.y, e.last, e.err);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({res_valid, res_y, res_op, res_last, res_err} !== 11'd0) begin
      failures++;
      $display("FAIL reset_res valid/y/op/last/err=%0b/%0d/%0d/%0b/%0b required=0",
               res_valid, res_y, res_op, res_last, res_err);
    end
    checks++;
    if ({calc_a, calc_b, calc_s} !== 11'b00000000_111) begin
      failures++;
      $display("FAIL reset_calc a/b/s=%0d/%0d/%0d required=0/0/7", calc_a, calc_b, calc_s);
    end
    checks++;
    if ({req_ready, busy} !== 2'b10) begin
      failures++;
      $display("FAIL reset_ready ready/busy=%0b/%0b required=1/0", req_ready, busy);
    end
  endtask

  task automatic test_all_ops();
    send(4'd9, 4'd5, 6'h3F, 1'b0);
    checks++;
    if ({res_valid, busy, req_ready, calc_s, calc_a, calc_b} !== {3'b010, 3'd0, 4'd9, 4'd5}) begin
      failures++;
      $display("FAIL issue_state valid/busy/ready/s/a/b=%0b/%0b/%0b/%0d/%0d/%0d required=0/1/0/0/9/5",
               res_valid, busy, req_ready, calc_s, calc_a, calc_b);
    end
    @(negedge clk);
    checks++;
    if ({res_valid, res_op} !== {1'b1, 3'd0}) begin
      failures++;
      $display("FAIL first_latency valid/op=%0b/%0d required=1/0", res_valid, res_op);
    end
    wait_drain("all_ops");
    checks++;
    if ({req_ready, busy, calc_s} !== {2'b10, 3'd7}) begin
      failures++;
      $display("FAIL all_ops_idle ready/busy/s=%0b/%0b/%0d required=1/0/7", req_ready, busy, calc_s);
    end
  endtask

  task automatic test_single();
    send(4'd3, 4'd7, 6'h02, 1'b0);
    wait_drain("single");
    send(4'd15, 4'd15, 6'h11, 1'b0);
    wait_drain("pair");
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1 res_ready = 1'b0;
    send(4'd2, 4'd4, 6'h05, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({res_valid, res_op, res_y, calc_s} !== {1'b1, 3'd0, 5'd6, 3'd0}) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d valid/op/y/s=%0b/%0d/%0d/%0d required=1/0/6/0",
                 i, res_valid, res_op, res_y, calc_s);
      end
      @(negedge clk);
    end
    @(posedge clk); #1 res_ready = 1'b1;
    wait_drain("bp");
  endtask

  task automatic test_mask_zero();
    send(4'd5, 4'd5, 6'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({res_valid, req_ready, busy} !== 3'b010) begin
        failures++;
        $display("FAIL mask_zero cyc=%0d valid/ready/busy=%0b/%0b/%0b required=0/1/0",
                 i, res_valid, req_ready, busy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    send(4'd9, 4'd5, 6'h3F, 1'b0);
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({res_valid, calc_s, req_ready} !== {1'b0, 3'd7, 1'b1}) begin
      failures++;
      $display("FAIL reset_mid valid/s/ready=%0b/%0d/%0b required=0/7/1", res_valid, calc_s, req_ready);
    end
    for (int i = 0; i < 12; i++) begin
      if (res_valid) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL reset_mid_quiet res_valid_seen=1 required=0");
    end
  endtask

  task automatic test_check_err();
`ifdef CALC_SEQ_CHECK_EN
    force_zero = 1'b1;
`endif
    send(4'd1, 4'd1, 6'h03, 1'b1);
    wait_drain("check_err");
    force_zero = 1'b0;
  endtask

  initial begin
    fork
      monitor();
      begin
        test_reset();
        test_all_ops();
        test_single();
        test_backpressure();
        test_mask_zero();
        test_reset_mid();
`ifdef CALC_SEQ_CHECK_EN
        test_check_err();
`endif
      end
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
